// File: rtl/logic_op_stream_if.sv
// Handshake bundle for logic_op_stream: operand beat in, buffered result out, occupancy.
// master = producer/consumer side, slave = the logic unit.
interface logic_op_stream_if #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/logic_op_stream.sv
// WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) feeding a FIFO_DEPTH-entry result buffer.
// Optional accumulator path enabled by defining LOGIC_OP_STREAM_ACCUM_EN.
module logic_op_stream #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
`ifdef LOGIC_OP_STREAM_ACCUM_EN
    input  logic                in_acc,
    input  logic                acc_clr,
`endif
    logic_op_stream_if.slave    bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;
    logic [WIDTH-1:0] opa, result;

    function automatic logic [WIDTH-1:0] logic_f(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Ready looks only at registered occupancy; a full buffer never passes through.
    assign bus.in_ready  = ena & (level_q != LW'(FIFO_DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = mem_q[rd_q];
    assign bus.level     = level_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

`ifdef LOGIC_OP_STREAM_ACCUM_EN
    logic [WIDTH-1:0] acc_q, acc_d;

    // Clear takes priority over the stored value for a beat on the same edge.
    assign opa    = in_acc ? (acc_clr ? '0 : acc_q) : bus.in_a;
    assign result = logic_f(opa, bus.in_b, bus.in_op);

    always_comb begin
        acc_d = acc_q;
        if (push && in_acc) acc_d = result;
        else if (acc_clr)   acc_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
`else
    assign opa    = bus.in_a;
    assign result = logic_f(opa, bus.in_b, bus.in_op);
`endif

    always_comb begin
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop  ? rd_q + 1'b1 : rd_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage is cleared on reset so out_data reads zero while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            if (push) mem_q[wr_q] <= result;
        end
    end
endmodule

// File: tb/tb_logic_op_stream.sv
// Scoreboard bench for logic_op_stream: drivers push expected results, a negedge monitor pops and compares.
// Accumulator scenario runs only when LOGIC_OP_STREAM_ACCUM_EN is defined.
module tb_logic_op_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic in_acc = 1'b0;
    logic acc_clr = 1'b0;

    logic_op_stream_if #(.WIDTH(8), .FIFO_DEPTH(4)) bus ();

    logic_op_stream #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
`ifdef LOGIC_OP_STREAM_ACCUM_EN
        .in_acc  (in_acc),
        .acc_clr (acc_clr),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] e;
    } vec_t;

    vec_t tbl [10] = '{
        '{8'h01, 8'hFF, 2'd2, 8'hFE},
        '{8'h12, 8'h34, 2'd0, 8'h10},
        '{8'h12, 8'h34, 2'd1, 8'h36},
        '{8'h12, 8'h34, 2'd2, 8'h26},
        '{8'h12, 8'h34, 2'd3, 8'hC9},
        '{8'hAA, 8'h55, 2'd0, 8'h00},
        '{8'hAA, 8'h55, 2'd1, 8'hFF},
        '{8'hAA, 8'h55, 2'd3, 8'h00},
        '{8'h0F, 8'h0F, 2'd2, 8'h00},
        '{8'h80, 8'h01, 2'd1, 8'h81}
    };

    logic [7:0] exp_q [$];
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: the transfer that happens at the next rising edge is visible at this negedge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
            else chk("sb_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
        end
    end

    // Offer one beat starting at posedge+1; returns at posedge+1 after it is accepted.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [7:0] e, input logic acc = 1'b0, input logic clr = 1'b0);
        bit done = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op;
        in_acc = acc; acc_clr = clr;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
            acc_clr = 1'b0;
        end
        if (!done) chk("accept_timeout", {31'h0, bus.in_ready}, 32'h1);
        bus.in_valid = 1'b0; in_acc = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && bus.level != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_level", {29'h0, bus.level}, 32'h0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level",     {29'h0, bus.level},     32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_data",  {24'h0, bus.out_data},  32'h0);
        chk("rst_in_ready",  {31'h0, bus.in_ready},  32'h0);
        rst = 1'b0; ena = 1'b1;
        @(posedge clk); #1;

        // 1: all four ops back to back, consumer always ready
        bus.out_ready = 1'b1;
        beat(8'hF0, 8'h3C, 2'd0, 8'h30);
        chk("t1_lat_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("t1_lat_data",  {24'h0, bus.out_data},  32'h30);
        beat(8'hF0, 8'h3C, 2'd1, 8'hFC);
        beat(8'hF0, 8'h3C, 2'd2, 8'hCC);
        beat(8'hF0, 8'h3C, 2'd3, 8'h03);
        chk("t1_level", {29'h0, bus.level}, 32'h1);
        chk("t1_last",  {24'h0, bus.out_data}, 32'h03);
        wait_empty();

        // 2: fill to depth, fifth beat held until a single pop
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].e);
        chk("t2_full_level", {29'h0, bus.level},    32'h4);
        chk("t2_full_ready", {31'h0, bus.in_ready}, 32'h0);
        fork
            beat(tbl[4].a, tbl[4].b, tbl[4].op, tbl[4].e);
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b1;
                @(posedge clk); #1 bus.out_ready = 1'b0;
            end
        join
        chk("t2_refill_level", {29'h0, bus.level}, 32'h4);
        bus.out_ready = 1'b1;
        wait_empty();

        // 3: full buffer with simultaneous push and pop, pointers wrap twice
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].e);
        bus.out_ready = 1'b1;
        fork
            for (int i = 0; i < 10; i++) beat(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].e);
            begin
                @(negedge clk);
                chk("t3_full_ready", {31'h0, bus.in_ready}, 32'h0);
                @(negedge clk);
                chk("t3_level_a", {29'h0, bus.level}, 32'h3);
                repeat (5) @(negedge clk);
                chk("t3_level_b", {29'h0, bus.level}, 32'h3);
            end
        join
        wait_empty();

        // 4: backpressure holds head stable; ena=0 blocks input while output drains
        bus.out_ready = 1'b0;
        for (int i = 1; i < 4; i++) beat(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].e);
        repeat (2) @(posedge clk);
        #1 chk("t4_hold_a", {24'h0, bus.out_data}, 32'h10);
        bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("t4_hold_b", {24'h0, bus.out_data}, 32'h36);
        ena = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.in_op = 2'd1;
        @(negedge clk);
        chk("t4_ena_ready", {31'h0, bus.in_ready}, 32'h0);
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t4_ena_level", {29'h0, bus.level},     32'h0);
        chk("t4_ena_valid", {31'h0, bus.out_valid}, 32'h0);
        bus.in_valid = 1'b0; ena = 1'b1;

        // 5: asynchronous reset with three results buffered
        bus.out_ready = 1'b0;
        for (int i = 1; i < 4; i++) beat(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].e);
        chk("t5_pre_level", {29'h0, bus.level}, 32'h3);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t5_level", {29'h0, bus.level},     32'h0);
        chk("t5_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("t5_data",  {24'h0, bus.out_data},  32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        beat(8'h0F, 8'hF0, 2'd1, 8'hFF);
        chk("t5_post_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("t5_post_data",  {24'h0, bus.out_data},  32'hFF);
        wait_empty();

`ifdef LOGIC_OP_STREAM_ACCUM_EN
        // 6: accumulator chain; in_a is deliberately junk to show it is ignored
        acc_clr = 1'b1;
        @(posedge clk); #1 acc_clr = 1'b0;
        beat(8'hFF, 8'h01, 2'd1, 8'h01, 1'b1);
        beat(8'hFF, 8'h02, 2'd1, 8'h03, 1'b1);
        beat(8'hFF, 8'h04, 2'd1, 8'h07, 1'b1);
        beat(8'hFF, 8'h10, 2'd1, 8'h10, 1'b1, 1'b1);
        beat(8'hFF, 8'h10, 2'd2, 8'h00, 1'b1);
        wait_empty();
`endif

        repeat (2) @(posedge clk);
        #1 chk("sb_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
